// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding and
// EX-stage forwarding select codes.
package pipe_ctrl_pkg;

  // Controller state: normal issue, waiting on data memory, or locked up after a timeout
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } hz_state_t;

  // EX operand source select
  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_NONE = 2'b00;  // register file value
  localparam fwd_sel_t FWD_WB   = 2'b01;  // result sitting in WB
  localparam fwd_sel_t FWD_MEM  = 2'b10;  // result sitting in MEM

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Datapath <-> hazard controller bundle. The datapath (master) drives the
// stage register addresses and status bits; the controller (slave) returns
// stall/flush enables, forwarding selects, the error flag and its FSM state.
// Optional PIPE_HAZARD_PERF_EN adds the stall_cycles/flush_count counters.
//
// Handshake: there is no valid/ready pairing on this bundle. dmem_req_m is a
// level that means "MEM issues an access this cycle" and dmem_ready_m is a
// level that means "the access completes this cycle"; a ready seen without a
// request while running carries no meaning and is ignored.
interface pipe_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5
);
  import pipe_ctrl_pkg::*;

  logic [REG_ADDR_W-1:0] rs_d, rt_d;
  logic [REG_ADDR_W-1:0] rs_e, rt_e;
  logic [REG_ADDR_W-1:0] register_d_e, register_d_m, register_d_w;
  logic                  wb_source_e, branch_taken_e;
  logic                  reg_write_m, reg_write_w;
  logic                  dmem_req_m, dmem_ready_m;

  logic                  stall_f, stall_d, stall_e, stall_m;
  logic                  flush_d, flush_e, flush_w;
  fwd_sel_t              fwd_a_e, fwd_b_e;
  logic                  mem_tmo_err;
  hz_state_t             state_dbg;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0]           stall_cycles, flush_count;
`endif

  modport master (
    output rs_d, rt_d, rs_e, rt_e, register_d_e, register_d_m, register_d_w,
    output wb_source_e, branch_taken_e, reg_write_m, reg_write_w,
    output dmem_req_m, dmem_ready_m,
    input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
    input  fwd_a_e, fwd_b_e, mem_tmo_err, state_dbg
`ifdef PIPE_HAZARD_PERF_EN
    , input stall_cycles, flush_count
`endif
  );

  modport slave (
    input  rs_d, rt_d, rs_e, rt_e, register_d_e, register_d_m, register_d_w,
    input  wb_source_e, branch_taken_e, reg_write_m, reg_write_w,
    input  dmem_req_m, dmem_ready_m,
    output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
    output fwd_a_e, fwd_b_e, mem_tmo_err, state_dbg
`ifdef PIPE_HAZARD_PERF_EN
    , output stall_cycles, flush_count
`endif
  );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
// Forwarding select for one EX source operand. A producer only counts when
// it writes a register other than $zero; MEM is younger than WB so it wins.
module fwd_select
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] src_e,
  input  logic [REG_ADDR_W-1:0] register_d_m,
  input  logic                  reg_write_m,
  input  logic [REG_ADDR_W-1:0] register_d_w,
  input  logic                  reg_write_w,
  output fwd_sel_t              sel
);

  logic mem_hit, wb_hit;

  assign mem_hit = reg_write_m && (register_d_m != '0) && (register_d_m == src_e);
  assign wb_hit  = reg_write_w && (register_d_w != '0) && (register_d_w == src_e);

  // Pick the youngest in-flight producer of this operand
  always_comb begin
    sel = FWD_NONE;
    if (mem_hit)     sel = FWD_MEM;
    else if (wb_hit) sel = FWD_WB;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller for the 5-stage pipeline. Stall/flush enables
// are decoded combinationally from the FSM state and the stage inputs; only
// the FSM state, the memory-wait counter and the sticky timeout error are
// registered. Optional macro: PIPE_HAZARD_PERF_EN (stall/flush counters).
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int          REG_ADDR_W  = 5,
  parameter int          TMO_W       = 8,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input logic              clk,
  input logic              reset,
  pipe_hazard_ctrl_if.slave hz
);

  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(MEM_TIMEOUT);
  localparam logic [TMO_W-1:0] CNT_MAX = '1;

  hz_state_t        state;
  logic [TMO_W-1:0] cnt;
  logic             tmo_err;

  logic mem_miss, load_use;
  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_w;

  // An access started this cycle that memory cannot finish yet
  assign mem_miss = hz.dmem_req_m && !hz.dmem_ready_m;

  // Load in EX feeding the instruction in ID
  assign load_use = hz.wb_source_e && (hz.register_d_e != '0) &&
                    ((hz.register_d_e == hz.rs_d) || (hz.register_d_e == hz.rt_d));

  // Stall/flush decode: memory wait masks everything, then branch, then load-use
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    unique case (state)
      RUN: begin
        if (mem_miss) begin
          {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
          flush_w = 1'b1;
        end else if (hz.branch_taken_e) begin
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (load_use) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end
      end
      MEM_WAIT: begin
        // EX is frozen here, so branch/load-use wait until RUN re-evaluates them
        if (!hz.dmem_ready_m) begin
          {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
          flush_w = 1'b1;
        end
      end
      default: begin
        {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
        flush_w = 1'b1;
      end
    endcase
  end

  // FSM: track outstanding memory access, time it out into HALT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RUN;
      cnt     <= '0;
      tmo_err <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (mem_miss) begin
            state <= MEM_WAIT;
            cnt   <= TMO_W'(1);
          end
        end
        MEM_WAIT: begin
          if (hz.dmem_ready_m) begin
            state <= RUN;
            cnt   <= '0;
          end else if (cnt == TMO_LIM) begin
            state   <= HALT;
            tmo_err <= 1'b1;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + TMO_W'(1);
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .src_e        (hz.rs_e),
    .register_d_m (hz.register_d_m),
    .reg_write_m  (hz.reg_write_m),
    .register_d_w (hz.register_d_w),
    .reg_write_w  (hz.reg_write_w),
    .sel          (hz.fwd_a_e)
  );

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .src_e        (hz.rt_e),
    .register_d_m (hz.register_d_m),
    .reg_write_m  (hz.reg_write_m),
    .register_d_w (hz.register_d_w),
    .reg_write_w  (hz.reg_write_w),
    .sel          (hz.fwd_b_e)
  );

  assign hz.stall_f     = stall_f;
  assign hz.stall_d     = stall_d;
  assign hz.stall_e     = stall_e;
  assign hz.stall_m     = stall_m;
  assign hz.flush_d     = flush_d;
  assign hz.flush_e     = flush_e;
  assign hz.flush_w     = flush_w;
  assign hz.mem_tmo_err = tmo_err;
  assign hz.state_dbg   = state;

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_cycles_q, flush_count_q;

  // Saturating counts of front-end stall cycles and EX bubble cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (stall_f && (stall_cycles_q != 32'hFFFF_FFFF))
        stall_cycles_q <= stall_cycles_q + 32'd1;
      if (flush_e && (flush_count_q != 32'hFFFF_FFFF))
        flush_count_q <= flush_count_q + 32'd1;
    end
  end

  assign hz.stall_cycles = stall_cycles_q;
  assign hz.flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with MEM_TIMEOUT=4. Control outputs are
// compared as a 7-bit vector {stall_f,stall_d,stall_e,stall_m,flush_d,flush_e,flush_w}.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  pipe_hazard_ctrl_if #(.REG_ADDR_W(5)) hz ();

  pipe_hazard_ctrl #(
    .REG_ADDR_W  (5),
    .TMO_W       (8),
    .MEM_TIMEOUT (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz.slave)
  );

  localparam logic [6:0] CTL_NONE = 7'b0000000;
  localparam logic [6:0] CTL_MEM  = 7'b1111001;
  localparam logic [6:0] CTL_LU   = 7'b1100010;
  localparam logic [6:0] CTL_BR   = 7'b0000110;

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic [6:0] exp);
    chk(tag, {25'd0, hz.stall_f, hz.stall_d, hz.stall_e, hz.stall_m,
                     hz.flush_d, hz.flush_e, hz.flush_w}, {25'd0, exp});
  endtask

  // ---------------- drivers ----------------
  task automatic idle();
    hz.rs_d = '0; hz.rt_d = '0; hz.rs_e = '0; hz.rt_e = '0;
    hz.register_d_e = '0; hz.register_d_m = '0; hz.register_d_w = '0;
    hz.wb_source_e = 1'b0; hz.branch_taken_e = 1'b0;
    hz.reg_write_m = 1'b0; hz.reg_write_w = 1'b0;
    hz.dmem_req_m = 1'b0; hz.dmem_ready_m = 1'b0;
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_use_vec();
    idle();
    hz.wb_source_e = 1'b1; hz.register_d_e = 5'd5; hz.rt_d = 5'd5;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    reset = 1'b1;
    #12;
    chk("rst_state_held", hz.state_dbg, RUN);
    chk("rst_err_held", hz.mem_tmo_err, 1'b0);
    @(negedge clk) reset = 1'b0;
    step();
    chk("rst_state", hz.state_dbg, RUN);
    chk_ctl("rst_ctl", CTL_NONE);
`ifdef PIPE_HAZARD_PERF_EN
    chk("rst_stall_cycles", hz.stall_cycles, 32'd0);
    chk("rst_flush_count", hz.flush_count, 32'd0);
`endif

    // forwarding
    hz.rs_e = 5'd3; hz.reg_write_m = 1'b1; hz.register_d_m = 5'd3;
    hz.reg_write_w = 1'b1; hz.register_d_w = 5'd3;
    #1 chk("fwd_a_mem_prio", hz.fwd_a_e, FWD_MEM);
    hz.register_d_m = 5'd0;
    #1 chk("fwd_a_wb", hz.fwd_a_e, FWD_WB);
    hz.reg_write_w = 1'b0;
    #1 chk("fwd_a_none", hz.fwd_a_e, FWD_NONE);
    idle();
    hz.rt_e = 5'd7; hz.reg_write_w = 1'b1; hz.register_d_w = 5'd7;
    #1 chk("fwd_b_wb", hz.fwd_b_e, FWD_WB);
    chk("fwd_a_indep", hz.fwd_a_e, FWD_NONE);
    hz.reg_write_m = 1'b1; hz.register_d_m = 5'd7;
    #1 chk("fwd_b_mem", hz.fwd_b_e, FWD_MEM);
    idle();
    hz.reg_write_w = 1'b1; hz.register_d_w = 5'd0;
    #1 chk("fwd_b_zero_reg", hz.fwd_b_e, FWD_NONE);

    // load-use
    step(); load_use_vec();
    #1 chk_ctl("lu_rt", CTL_LU);
    step(); idle();
    #1 chk_ctl("lu_bubble", CTL_NONE);
    hz.wb_source_e = 1'b1; hz.register_d_e = 5'd0;
    #1 chk_ctl("lu_zero_reg", CTL_NONE);
    hz.register_d_e = 5'd9; hz.rs_d = 5'd9;
    #1 chk_ctl("lu_rs", CTL_LU);
    hz.wb_source_e = 1'b0;
    #1 chk_ctl("lu_not_load", CTL_NONE);

    // branch beats load-use
    step(); load_use_vec(); hz.branch_taken_e = 1'b1;
    #1 chk_ctl("br_over_lu", CTL_BR);

    // multi-cycle memory access: three low cycles then ready
    step(); idle(); hz.dmem_req_m = 1'b1;
    #1 chk_ctl("mw_a", CTL_MEM);
    step();
    chk("mw_state", hz.state_dbg, MEM_WAIT);
    load_use_vec(); hz.branch_taken_e = 1'b1;
    #1 chk_ctl("mw_b_masked", CTL_MEM);
    step(); idle(); hz.dmem_req_m = 1'b1;
    #1 chk_ctl("mw_c", CTL_MEM);
    step(); hz.dmem_ready_m = 1'b1;
    #1 chk_ctl("mw_d_ready", CTL_NONE);
    step(); idle();
    chk("mw_back_run", hz.state_dbg, RUN);
    #1 chk_ctl("mw_run_idle", CTL_NONE);
    hz.dmem_req_m = 1'b1; hz.dmem_ready_m = 1'b1;
    #1 chk_ctl("mem_hit_fast", CTL_NONE);
    step(); idle(); hz.dmem_ready_m = 1'b1;
    chk("mem_fast_run", hz.state_dbg, RUN);
    step();
    chk("stray_ready_run", hz.state_dbg, RUN);

    // timeout into HALT
    idle(); hz.dmem_req_m = 1'b1;
    #1 chk_ctl("to_start", CTL_MEM);
    step();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to_state%0d", i), hz.state_dbg, MEM_WAIT);
      chk($sformatf("to_err%0d", i), hz.mem_tmo_err, 1'b0);
      #1 chk_ctl($sformatf("to_ctl%0d", i), CTL_MEM);
      step();
    end
    chk("halt_state", hz.state_dbg, HALT);
    chk("halt_err", hz.mem_tmo_err, 1'b1);
    idle(); hz.dmem_ready_m = 1'b1;
    #1 chk_ctl("halt_ctl", CTL_MEM);
    step();
    chk("halt_sticky", hz.state_dbg, HALT);
    chk("halt_err_sticky", hz.mem_tmo_err, 1'b1);
    idle();
    #2 reset = 1'b1;
    #1 chk("async_rst_state", hz.state_dbg, RUN);
    chk("async_rst_err", hz.mem_tmo_err, 1'b0);
    chk_ctl("async_rst_ctl", CTL_NONE);
    @(negedge clk) reset = 1'b0;

    // reset mid-MEM_WAIT
    step(); hz.dmem_req_m = 1'b1;
    step(); idle();
    chk("mid_wait_state", hz.state_dbg, MEM_WAIT);
    #2 reset = 1'b1;
    #1 chk("mid_wait_rst_state", hz.state_dbg, RUN);
    chk_ctl("mid_wait_rst_ctl", CTL_NONE);
    @(negedge clk) reset = 1'b0;

    // after reset a fresh wait must take the full four cycles again
    step(); hz.dmem_req_m = 1'b1;
    step(); idle();
    for (int i = 0; i < 3; i++) step();
    chk("cnt_cleared_wait", hz.state_dbg, MEM_WAIT);
    hz.dmem_ready_m = 1'b1;
    step(); idle();
    chk("cnt_cleared_run", hz.state_dbg, RUN);

`ifdef PIPE_HAZARD_PERF_EN
    // counters: 2 load-use stalls + 1 branch
    #2 reset = 1'b1;
    #1 chk("perf_rst_stall", hz.stall_cycles, 32'd0);
    @(negedge clk) reset = 1'b0;
    step(); load_use_vec();
    step(); idle();
    step(); load_use_vec();
    step(); idle(); hz.branch_taken_e = 1'b1;
    step(); idle();
    step();
    chk("perf_stall_cycles", hz.stall_cycles, 32'd2);
    chk("perf_flush_count", hz.flush_count, 32'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the bench always ends on its own
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
